alu_share_ctrl: RTL and testbench

//  Shares one 32-bit combinational ALU (ops ADD..SRA, 4-bit opcode, Zero flag) among NUM_REQ requesters.

---
 rtl/alu_pkg.sv | 29 ++
 rtl/alu.sv | 35 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/alu_share_ctrl.sv | 137 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU controller: datapath widths, ALU opcodes,
// controller FSM states and the captured-operation record.
package alu_pkg;

    localparam int XLEN    = 32;
    localparam int ALU_OPW = 4;

    localparam logic [ALU_OPW-1:0] ALU_ADD = 4'b0000;
    localparam logic [ALU_OPW-1:0] ALU_SUB = 4'b0001;
    localparam logic [ALU_OPW-1:0] ALU_AND = 4'b0010;
    localparam logic [ALU_OPW-1:0] ALU_OR  = 4'b0011;
    localparam logic [ALU_OPW-1:0] ALU_XOR = 4'b0100;
    localparam logic [ALU_OPW-1:0] ALU_SLL = 4'b0101;
    localparam logic [ALU_OPW-1:0] ALU_SRL = 4'b0110;
    localparam logic [ALU_OPW-1:0] ALU_SRA = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    typedef struct packed {
        logic [XLEN-1:0]    a;
        logic [XLEN-1:0]    b;
        logic [ALU_OPW-1:0] op;
    } alu_op_t;

endpackage

// File: rtl/alu.sv
// Shared 32-bit combinational ALU: ADD..SRA, shifts by b[4:0].
// Opcodes 8..15 produce a zero result.
module alu
    import alu_pkg::*;
(
    input  logic [XLEN-1:0]    a,
    input  logic [XLEN-1:0]    b,
    input  logic [ALU_OPW-1:0] op,
    output logic [XLEN-1:0]    result,
    output logic               zero
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = XLEN'($signed(a) >>> shamt);
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr,
// wrapping modulo NUM_REQ.
module rr_arbiter #(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     grant_idx,
    output logic               grant_valid
);

    logic [IDW-1:0] idx;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        idx         = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!grant_valid && req[idx]) begin
                grant_valid = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = idx;
            end
        end
    end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU among NUM_REQ requesters: round-robin grant, operand capture,
// registered result and a valid/ready response. One operation in flight at a time.
module alu_share_ctrl
    import alu_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*XLEN-1:0]    req_a,
    input  logic [NUM_REQ*XLEN-1:0]    req_b,
    input  logic [NUM_REQ*ALU_OPW-1:0] req_op,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [XLEN-1:0]            rsp_result,
    output logic                       rsp_zero,
    output logic                       rsp_illegal,
    output logic [IDW-1:0]             rsp_id,
    output logic                       busy
);

    state_e             state, state_nxt;
    logic [IDW-1:0]     rr_ptr;
    logic [IDW-1:0]     id_q;
    alu_op_t            op_q;
    alu_op_t            sel_op;

    logic [NUM_REQ-1:0] grant;
    logic [IDW-1:0]     grant_idx;
    logic               grant_valid;
    logic               accept;
    logic               capture;
    logic               rsp_done;

    logic [XLEN-1:0]    alu_result;
    logic               alu_zero;

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req         (req_valid),
        .ptr         (rr_ptr),
        .grant       (grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    // The ALU only ever sees the captured operands, never the live request ports.
    alu u_alu (
        .a      (op_q.a),
        .b      (op_q.b),
        .op     (op_q.op),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        sel_op = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_op.a  = req_a[XLEN*i +: XLEN];
                sel_op.b  = req_b[XLEN*i +: XLEN];
                sel_op.op = req_op[ALU_OPW*i +: ALU_OPW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = '0;
        accept    = 1'b0;
        capture   = 1'b0;
        rsp_done  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_valid) begin
                    // Gated by rst_n so no requester sees ready while reset is held.
                    req_ready = rst_n ? grant : '0;
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture   = 1'b1;
                state_nxt = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_done  = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q        <= '0;
            id_q        <= '0;
            rr_ptr      <= '0;
            rsp_result  <= '0;
            rsp_zero    <= 1'b0;
            rsp_illegal <= 1'b0;
            rsp_id      <= '0;
        end else begin
            if (accept) begin
                op_q <= sel_op;
                id_q <= grant_idx;
            end
            if (capture) begin
                rsp_result  <= alu_result;
                rsp_zero    <= alu_zero;
                rsp_illegal <= op_q.op[ALU_OPW-1];
                rsp_id      <= id_q;
            end
            // Next search starts just past the requester that was served.
            if (rsp_done) begin
                rr_ptr <= (id_q == IDW'(NUM_REQ - 1)) ? '0 : id_q + IDW'(1);
            end
        end
    end

    assign rsp_valid = (state == ST_RESP);
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Randomized scoreboard bench for alu_share_ctrl: a driver predicts grants and
// results from a round-robin/ALU reference model; a monitor checks responses.
module tb_alu_share_ctrl;
    import alu_pkg::*;

    localparam int N   = 4;
    localparam int IDW = $clog2(N);

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
    } txn_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          id;
        int          t_acc;
    } exp_t;

    logic              clk;
    logic              rst_n;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*32-1:0]   req_a;
    logic [N*32-1:0]   req_b;
    logic [N*4-1:0]    req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_result;
    logic              rsp_zero;
    logic              rsp_illegal;
    logic [IDW-1:0]    rsp_id;
    logic              busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   m_ptr   = 0;
    bit   done    = 0;
    txn_t stim_q[N][$];
    exp_t sb[$];

    alu_share_ctrl #(.NUM_REQ(N)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_op      (req_op),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_result  (rsp_result),
        .rsp_zero    (rsp_zero),
        .rsp_illegal (rsp_illegal),
        .rsp_id      (rsp_id),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        int sh;
        sh = int'(b % 32);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return a << sh;
            4'd6:    return a >> sh;
            4'd7:    return 32'($signed(a) >>> sh);
            default: return 32'd0;
        endcase
    endfunction

    // Round robin: first valid requester at or after ptr, wrapping.
    function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_rsp_valid"},   32'(rsp_valid),   32'd0);
        check({tag, "_rsp_result"},  rsp_result,       32'd0);
        check({tag, "_rsp_zero"},    32'(rsp_zero),    32'd0);
        check({tag, "_rsp_illegal"}, 32'(rsp_illegal), 32'd0);
        check({tag, "_rsp_id"},      32'(rsp_id),      32'd0);
        check({tag, "_busy"},        32'(busy),        32'd0);
        check({tag, "_req_ready"},   32'(req_ready),   32'd0);
    endtask

    task automatic load_stimulus();
        txn_t t;
        stim_q[0].push_back('{32'd5, 32'd7, ALU_ADD});
        stim_q[0].push_back('{32'd9, 32'd9, ALU_SUB});
        stim_q[1].push_back('{32'h8000_0000, 32'h24, ALU_SRA});
        stim_q[2].push_back('{32'd1, 32'd31, ALU_SLL});
        stim_q[3].push_back('{32'd3, 32'd4, 4'b1010});
        stim_q[3].push_back('{32'd3, 32'd4, ALU_ADD});
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < 25; j++) begin
                t.a  = $urandom;
                t.b  = ($urandom_range(0, 3) == 0) ? t.a : $urandom;
                t.op = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
                stim_q[i].push_back(t);
            end
        end
    endtask

    task automatic driver();
        txn_t cur[N];
        int   last_g = -1;
        int   g;
        bit   withdrew;
        bit   pending;
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (last_g >= 0) req_valid[last_g] = 1'b0;
            pending = 0;
            for (int i = 0; i < N; i++) if (stim_q[i].size() > 0) pending = 1;
            if (!pending && req_valid == '0 && sb.size() == 0) break;
            if (cyc > 20000) begin
                n_tests++;
                n_fail++;
                $display("FAIL timeout: run still active at cycle %0d, expected completion", cyc);
                break;
            end
            for (int i = 0; i < N; i++) begin
                withdrew = 0;
                if (req_valid[i] && i != last_g && $urandom_range(0, 15) == 0) begin
                    stim_q[i].push_front(cur[i]);
                    req_valid[i] = 1'b0;
                    withdrew = 1;
                end
                if (!req_valid[i] && !withdrew && stim_q[i].size() > 0 && $urandom_range(0, 3) != 0) begin
                    cur[i] = stim_q[i].pop_front();
                    req_a[32*i +: 32] = cur[i].a;
                    req_b[32*i +: 32] = cur[i].b;
                    req_op[4*i +: 4]  = cur[i].op;
                    req_valid[i]      = 1'b1;
                end
            end
            rsp_ready = ((cyc % 60) >= 20 && (cyc % 60) < 32) ? 1'b0 : ($urandom_range(0, 3) != 0);
            #1;
            g = (sb.size() == 0) ? rr_pick(req_valid, m_ptr) : -1;
            check("req_ready", 32'(req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
            if (g >= 0) begin
                e.res   = ref_alu(cur[g].a, cur[g].b, cur[g].op);
                e.zero  = (e.res == 32'd0);
                e.ill   = (cur[g].op >= 4'd8);
                e.id    = g;
                e.t_acc = cyc;
                sb.push_back(e);
            end
            last_g = g;
        end
        done = 1;
    endtask

    task automatic monitor();
        exp_t e;
        bit   front_seen = 0;
        forever begin
            @(negedge clk);
            #2;
            if (done) break;
            if (sb.size() == 0) begin
                check("rsp_valid_idle", 32'(rsp_valid), 32'd0);
                check("busy_idle",      32'(busy),      32'd0);
            end else begin
                e = sb[0];
                check("busy", 32'(busy), (cyc > e.t_acc) ? 32'd1 : 32'd0);
                if (rsp_valid) begin
                    if (!front_seen) begin
                        check("latency", 32'(cyc - e.t_acc), 32'd2);
                        front_seen = 1;
                    end
                    check("rsp_result",  rsp_result,       e.res);
                    check("rsp_zero",    32'(rsp_zero),    32'(e.zero));
                    check("rsp_illegal", 32'(rsp_illegal), 32'(e.ill));
                    check("rsp_id",      32'(rsp_id),      32'(e.id));
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        front_seen = 0;
                        m_ptr = (e.id + 1) % N;
                    end
                end else if (cyc >= e.t_acc + 2) begin
                    check("rsp_valid_missing", 32'(rsp_valid), 32'd1);
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        load_stimulus();

        repeat (3) @(negedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Accept one op, then reset while it is executing: it must vanish.
        @(negedge clk);
        req_valid    = 4'b0001;
        req_a[31:0]  = 32'd5;
        req_b[31:0]  = 32'd7;
        req_op[3:0]  = ALU_ADD;
        #1;
        check("pre_reset_req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = '0;
        #1;
        check("exec_busy",      32'(busy),      32'd1);
        check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
        req_valid = 4'b0001;
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_exec_reset");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
            check("post_reset_busy",      32'(busy),      32'd0);
        end

        fork
            driver();
            monitor();
        join

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
